// File: rtl/mcycle_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
// Latency: n/a (types and constants only).
// Backpressure: none.
package mcycle_pkg;

  // State encodings; values 13-15 are unused and decode as idle.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_BGEZ   = 4'd9,
    S_ORIEX  = 4'd10,
    S_ORIWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  // Opcodes from IR[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // aluOp encoding understood by the downstream ALU-control decoder.
  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_FUNC = 3'b010;
  localparam logic [2:0] ALUOP_BGEZ = 3'b011;
  localparam logic [2:0] ALUOP_ORI  = 3'b100;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full datapath control word.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       pc_write;
    logic       pc_write_cond;
    logic       br_type;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mcycle_control_outdec.sv
// State-to-control-word decoder for the multicycle control FSM.
// Latency: purely combinational. Backpressure: none.
// Ports: state_i (raw state bits) -> ctrl_o (full control word).
module mcycle_control_outdec
  import mcycle_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      // Precompute the branch target into ALUOut while the opcode decodes.
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_BOFF;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.ior_d     = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_FUNC;
      end
      S_RWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REGB;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.br_type       = 1'b0;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_BGEZ: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REGB;
        ctrl_o.alu_op        = ALUOP_BGEZ;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.br_type       = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_ORIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.ext_op    = 1'b1;
        ctrl_o.alu_op    = ALUOP_ORI;
      end
      S_ORIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mcycle_control.sv
// Multicycle MIPS main control: registered Moore FSM driving datapath controls.
// Latency: outputs decode the current state combinationally; op steers next state.
// Backpressure: none; one state per clock, reset forces all outputs to zero.
// Ports: clk, reset (sync, active-high), op (IR[31:26]); outputs are the
// datapath enables/selects, aluOp for ALU control, and state for debug.
module mcycle_control
  import mcycle_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  output logic [2:0]         aluOp,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic               extOp,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               regWrite,
  output logic               memtoReg,
  output logic               regDst,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               brType,
  output logic [1:0]         pcSource,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  ctrl_t  dec_ctrl, ctrl;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_BGEZ:      state_d = S_BGEZ;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;  // unknown opcode runs as a NOP
        endcase
      end
      // IR is not rewritten after FETCH, so op still names this instruction.
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ORIEX:  state_d = S_ORIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  mcycle_control_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (dec_ctrl)
  );

  // Reset squashes the whole control word so an aborted instruction cannot
  // write anything during the reset cycle.
  assign ctrl = reset ? '0 : dec_ctrl;

  assign aluOp       = ctrl.alu_op;
  assign aluSrcA     = ctrl.alu_src_a;
  assign aluSrcB     = ctrl.alu_src_b;
  assign extOp       = ctrl.ext_op;
  assign iorD        = ctrl.ior_d;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign irWrite     = ctrl.ir_write;
  assign regWrite    = ctrl.reg_write;
  assign memtoReg    = ctrl.mem_to_reg;
  assign regDst      = ctrl.reg_dst;
  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign brType      = ctrl.br_type;
  assign pcSource    = ctrl.pc_source;
  assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_mcycle_control.sv
// Directed bench for mcycle_control with a queue-based scoreboard.
// Stimulus pushes the hand-derived expected state/control word per cycle;
// a monitor on the falling edge pops and compares against the DUT.
module tb_mcycle_control;

  // Expected control word, same field order as the DUT output concatenation.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic       m2r;
    logic       rdst;
    logic       pcw;
    logic       pcwc;
    logic       brt;
    logic [1:0] pcsrc;
  } exp_t;

  typedef struct {
    logic [3:0] st;
    exp_t       cw;
    string      name;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [2:0] aluOp;
  logic       aluSrcA, extOp, iorD, memRead, memWrite, irWrite, regWrite;
  logic       memtoReg, regDst, pcWrite, pcWriteCond, brType;
  logic [1:0] aluSrcB, pcSource;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  entry_t sb[$];

  always #5 clk = ~clk;

  mcycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op),
    .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .extOp(extOp),
    .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regWrite(regWrite), .memtoReg(memtoReg), .regDst(regDst),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .brType(brType),
    .pcSource(pcSource), .state(state)
  );

  // Hand-written control table, one entry per state.
  function automatic exp_t expect_cw(input logic [3:0] st);
    exp_t e;
    e = '0;
    case (st)
      4'd0:  begin e.mrd = 1; e.irw = 1; e.src_b = 2'b01; e.pcw = 1; end
      4'd1:  begin e.src_b = 2'b11; end
      4'd2:  begin e.src_a = 1; e.src_b = 2'b10; end
      4'd3:  begin e.mrd = 1; e.iord = 1; end
      4'd4:  begin e.rw = 1; e.m2r = 1; end
      4'd5:  begin e.mwr = 1; e.iord = 1; end
      4'd6:  begin e.src_a = 1; e.alu_op = 3'b010; end
      4'd7:  begin e.rw = 1; e.rdst = 1; end
      4'd8:  begin e.src_a = 1; e.alu_op = 3'b001; e.pcwc = 1; e.pcsrc = 2'b01; end
      4'd9:  begin e.src_a = 1; e.alu_op = 3'b011; e.pcwc = 1; e.brt = 1; e.pcsrc = 2'b01; end
      4'd10: begin e.src_a = 1; e.src_b = 2'b10; e.ext = 1; e.alu_op = 3'b100; end
      4'd11: begin e.rw = 1; end
      4'd12: begin e.pcw = 1; e.pcsrc = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // One clock of stimulus: drive inputs for this cycle, queue what the DUT
  // should show during it, then advance past the next rising edge.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [3:0] st,
                     input string name);
    entry_t en;
    reset = r;
    op    = o;
    en.st   = st;
    en.cw   = r ? exp_t'('0) : expect_cw(st);
    en.name = name;
    sb.push_back(en);
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      entry_t en;
      exp_t   act;
      en  = sb.pop_front();
      act = {aluOp, aluSrcA, aluSrcB, extOp, iorD, memRead, memWrite, irWrite,
             regWrite, memtoReg, regDst, pcWrite, pcWriteCond, brType, pcSource};
      checks++;
      if (state !== en.st) begin
        errors++;
        $display("FAIL %s state: got %0d want %0d", en.name, state, en.st);
      end
      checks++;
      if (act !== en.cw) begin
        errors++;
        $display("FAIL %s ctrl: got %05h want %05h", en.name, act, en.cw);
      end
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BGZ = 6'b000001, ORI = 6'b001101;
  localparam logic [5:0] JMP = 6'b000010, ILL = 6'b111111;

  initial begin
    reset = 1'b1;
    op    = LW;
    @(posedge clk);
    #1;
    // Reset held: FETCH loaded, all outputs zero.
    cyc(1, LW, 4'd0, "rst0");
    cyc(1, LW, 4'd0, "rst1");
    // lw: 5 cycles
    cyc(0, LW, 4'd0, "lw_fetch");
    cyc(0, LW, 4'd1, "lw_decode");
    cyc(0, LW, 4'd2, "lw_memadr");
    cyc(0, LW, 4'd3, "lw_memrd");
    cyc(0, LW, 4'd4, "lw_memwb");
    // R-type: 4 cycles
    cyc(0, RT, 4'd0, "r_fetch");
    cyc(0, RT, 4'd1, "r_decode");
    cyc(0, RT, 4'd6, "r_exec");
    cyc(0, RT, 4'd7, "r_rwb");
    // beq then bgez: 3 cycles each
    cyc(0, BEQ, 4'd0, "beq_fetch");
    cyc(0, BEQ, 4'd1, "beq_decode");
    cyc(0, BEQ, 4'd8, "beq_br");
    cyc(0, BGZ, 4'd0, "bgez_fetch");
    cyc(0, BGZ, 4'd1, "bgez_decode");
    cyc(0, BGZ, 4'd9, "bgez_br");
    // ori: 4 cycles
    cyc(0, ORI, 4'd0, "ori_fetch");
    cyc(0, ORI, 4'd1, "ori_decode");
    cyc(0, ORI, 4'd10, "ori_ex");
    cyc(0, ORI, 4'd11, "ori_wb");
    // sw: 4 cycles
    cyc(0, SW, 4'd0, "sw_fetch");
    cyc(0, SW, 4'd1, "sw_decode");
    cyc(0, SW, 4'd2, "sw_memadr");
    cyc(0, SW, 4'd5, "sw_memwr");
    // illegal opcode: 2 cycles
    cyc(0, ILL, 4'd0, "ill_fetch");
    cyc(0, ILL, 4'd1, "ill_decode");
    // j: 3 cycles
    cyc(0, JMP, 4'd0, "j_fetch");
    cyc(0, JMP, 4'd1, "j_decode");
    cyc(0, JMP, 4'd12, "j_jump");
    // lw aborted by reset during MEMRD: MEMRD outputs squashed, no MEMWB.
    cyc(0, LW, 4'd0, "ab_fetch");
    cyc(0, LW, 4'd1, "ab_decode");
    cyc(0, LW, 4'd2, "ab_memadr");
    cyc(1, LW, 4'd3, "ab_memrd_rst");
    // Next instruction runs normally.
    cyc(0, RT, 4'd0, "post_fetch");
    cyc(0, RT, 4'd1, "post_decode");
    cyc(0, RT, 4'd6, "post_exec");
    cyc(0, RT, 4'd7, "post_rwb");
    cyc(0, RT, 4'd0, "post_fetch2");
    // Let the monitor drain the last entry.
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
